// File: rtl/eq_fir_tap_sequencer.sv
// eq_fir_tap_sequencer: time-multiplexed 16-tap symmetric FIR using one shared pre-add/multiply/accumulate
module eq_fir_tap_sequencer #(
    parameter logic [7:0] C0 = 8'd3,
    parameter logic [7:0] C1 = 8'd8,
    parameter logic [7:0] C2 = 8'd19,
    parameter logic [7:0] C3 = 8'd40,
    parameter logic [7:0] C4 = 8'd69,
    parameter logic [7:0] C5 = 8'd101,
    parameter logic [7:0] C6 = 8'd128,
    parameter logic [7:0] C7 = 8'd143,
    parameter int OUT_SHIFT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [7:0]  sample_in,
    input  logic        flush,
    output logic        busy,
    output logic        result_valid,
    output logic [19:0] result,
    output logic [7:0]  y_out,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    state_t state, state_nxt;
    logic [7:0] hist [16];
    logic [3:0] wr_ptr, newest, idx_a, idx_b;
    logic [2:0] k;
    logic [19:0] acc, shifted;
    logic [7:0] coef;
    logic [8:0] pre;
    logic [16:0] prod;
    // tap pair k folds the k-th newest sample with the (15-k)-th newest
    assign idx_a = newest - {1'b0, k};
    assign idx_b = newest + 4'd1 + {1'b0, k};
    assign pre = {1'b0, hist[idx_a]} + {1'b0, hist[idx_b]};
    assign prod = {8'd0, pre} * {9'd0, coef};
    assign shifted = acc >> OUT_SHIFT;
    assign busy = state != IDLE;
    // coefficient select for the current folded tap pair
    always_comb begin
        coef = (k == 3'd0) ? C0 : (k == 3'd1) ? C1 : (k == 3'd2) ? C2 : (k == 3'd3) ? C3 :
               (k == 3'd4) ? C4 : (k == 3'd5) ? C5 : (k == 3'd6) ? C6 : C7;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    // next state: accept in IDLE, eight MAC cycles, one DONE cycle
    always_comb begin
        state_nxt = IDLE;
        state_nxt = (state == IDLE) ? (sample_valid ? MAC : IDLE) :
                    (state == MAC)  ? ((k == 3'd7) ? DONE : MAC) : IDLE;
    end
    // history buffer, accumulator and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) hist[i] <= '0;
            wr_ptr <= '0;
            newest <= '0;
            k <= '0;
            acc <= '0;
            result <= '0;
            y_out <= '0;
            result_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            overrun <= sample_valid && busy;
            if (state == IDLE && sample_valid) begin
                hist[wr_ptr] <= sample_in;
                newest <= wr_ptr;
                wr_ptr <= wr_ptr + 4'd1;
                acc <= '0;
                k <= '0;
            end else if (state == IDLE && flush) begin
                for (int i = 0; i < 16; i++) hist[i] <= '0;
            end else if (state == MAC) begin
                acc <= acc + {3'd0, prod};
                k <= k + 3'd1;
            end else if (state == DONE) begin
                result <= acc;
                y_out <= (|shifted[19:8]) ? 8'hFF : shifted[7:0];
                result_valid <= 1'b1;
            end
        end
    end
endmodule
